// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  // Default memory depth in words and the matching words_loaded width.
  localparam int DEPTH_DEF = 32;
  localparam int WL_W      = $clog2(DEPTH_DEF + 1);

  // Load sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  // Byte address of a word index (word index lives in A[31:2]).
  function automatic logic [31:0] word_addr(input logic [WL_W-1:0] idx);
    return {{(30 - WL_W){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler: collects four bytes and presents
// the finished word together with a one-cycle valid pulse on the next cycle.
module imem_loader_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  byte_idx_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q,   idx_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] word_q,  word_d;
  logic        valid_q, valid_d;

  // Next-state: clear wins, otherwise shift a pushed byte into place.
  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clr_i) begin
      idx_d   = 2'd0;
      shift_d = 24'd0;
    end else if (push_i) begin
      idx_d   = idx_q + 2'd1;
      shift_d = {byte_i, shift_q[23:8]};
      if (idx_q == 2'd3) begin
        word_d  = {byte_i, shift_q};
        valid_d = 1'b1;
      end else begin
        word_d  = word_q;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // State register; the finished word holds until the next one completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign byte_idx_o   = idx_q;
  assign word_valid_o = valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses LEN / data / CHK frames from a byte
// stream, writes words into the instruction memory and holds the CPU until
// a checksum-verified image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = 1000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output logic            WE,
  output logic [31:0]     WA,
  output logic [31:0]     WD,
  output logic            cpu_hold,
  output logic            done,
  output logic            error,
  output logic [WL_W-1:0] words_loaded
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [WL_W-1:0] len_q,   len_d;
  logic [WL_W-1:0] wl_q,    wl_d;
  logic [31:0]     wa_q,    wa_d;
  logic [7:0]      chk_q,   chk_d;
  logic [TO_W-1:0] to_q,    to_d;
  logic            done_q,  done_d;
  logic            err_q,   err_d;
  logic            hold_q,  hold_d;

  logic            active_s;
  logic            accept_s;
  logic            expire_s;
  logic            asm_clr_s;
  logic            asm_push_s;
  logic [1:0]      asm_idx_s;
  logic            asm_valid_s;
  logic [31:0]     asm_word_s;

  assign active_s   = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHECK);
  assign accept_s   = rx_valid && active_s;
  assign expire_s   = !accept_s && (to_q == TO_W'(TIMEOUT - 1));
  assign asm_push_s = accept_s && (state_q == ST_DATA);

  imem_loader_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (asm_clr_s),
    .push_i       (asm_push_s),
    .byte_i       (rx_data),
    .byte_idx_o   (asm_idx_s),
    .word_valid_o (asm_valid_s),
    .word_o       (asm_word_s)
  );

  // Frame sequencing, checksum, word addressing and idle timeout.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wl_d      = wl_q;
    wa_d      = wa_q;
    chk_d     = chk_q;
    to_d      = to_q;
    done_d    = done_q;
    err_d     = err_q;
    hold_d    = hold_q;
    asm_clr_s = 1'b0;
    if (active_s) begin
      if (accept_s) begin
        to_d = '0;
      end else if (expire_s) begin
        state_d = ST_ERROR;
        err_d   = 1'b1;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end else begin
      to_d = to_q;
    end
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d   = ST_LEN;
          done_d    = 1'b0;
          err_d     = 1'b0;
          wl_d      = '0;
          chk_d     = 8'd0;
          to_d      = '0;
          hold_d    = 1'b1;
          asm_clr_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN: begin
        if (accept_s) begin
          if ((rx_data == 8'd0) || ({24'd0, rx_data} > 32'(DEPTH))) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            len_d   = rx_data[WL_W-1:0];
            state_d = ST_DATA;
          end
        end else begin
          len_d = len_q;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          chk_d = chk_q ^ rx_data;
          if (asm_idx_s == 2'd3) begin
            wa_d = word_addr(wl_q);
            wl_d = wl_q + WL_W'(1);
            if ((wl_q + WL_W'(1)) == len_q) begin
              state_d = ST_CHECK;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            wl_d = wl_q;
          end
        end else begin
          chk_d = chk_q;
        end
      end
      ST_CHECK: begin
        if (accept_s) begin
          if (rx_data == chk_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end else begin
          chk_d = chk_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      wl_q    <= '0;
      wa_q    <= 32'd0;
      chk_q   <= 8'd0;
      to_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wl_q    <= wl_d;
      wa_q    <= wa_d;
      chk_q   <= chk_d;
      to_q    <= to_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign rx_ready     = active_s;
  assign WE           = asm_valid_s;
  assign WA           = wa_q;
  assign WD           = asm_word_s;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign error        = err_q;
  assign words_loaded = wl_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a byte stream (from the UART receiver or a testbench), assembles little-endian 32-bit words, and issues single-word write strobes into the instruction memory array.
- Addresses are byte addresses with word index in A[31:2], matching the memory's read indexing.
- Holds the processor stalled until a complete, checksum-verified image is loaded.

Parameters:
- DEPTH, 32, instruction memory size in words; legal image lengths are 1..DEPTH.
- TIMEOUT, 1000000, maximum idle cycles between accepted bytes while loading before aborting.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle; a byte transfers when rx_valid && rx_ready.
- WE  output  1  instruction memory write strobe, one cycle per word.
- WA  output  32  write byte address, always word-aligned (WA[1:0]=0).
- WD  output  32  write data word.
- cpu_hold  output  1  keeps the processor stalled or in reset while high.
- done  output  1  image loaded and checksum matched; sticky until next start.
- error  output  1  load aborted; sticky until next start.
- words_loaded  output  6  count of words written in the current load (0..DEPTH).

Behaviour:
- Reset (async, reset=0) values:
  - state=IDLE; rx_ready=0, WE=0, WA=0, WD=0, done=0, error=0, words_loaded=0.
  - cpu_hold=1.
  - Byte counter, checksum accumulator and timeout counter cleared.
- Frame format: LEN byte (N words), then 4N data bytes with the least-significant byte first, then a CHK byte equal to the XOR of all 4N data bytes.
- States: IDLE, LEN, DATA, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR:
  - rx_ready=0.
  - start -> LEN; clears done, error, words_loaded, checksum and timeout counter; sets cpu_hold=1.
- start while in LEN, DATA or CHECK is ignored.
- LEN:
  - rx_ready=1.
  - On an accepted byte: if 0 or >DEPTH -> ERROR; else latch N and go to DATA.
- DATA:
  - rx_ready=1.
  - Each accepted byte is shifted into the word at position byte_idx (0..3) and XORed into the checksum.
  - On acceptance of the 4th byte:
    - In the next cycle, WE=1 for exactly one cycle, WA = words_loaded*4, WD = assembled word.
    - words_loaded increments in that same cycle.
  - After the Nth word's byte 3 is accepted -> CHECK.
  - Back-to-back bytes every cycle are legal; the write pipeline must not stall rx_ready.
- CHECK:
  - rx_ready=1.
  - Accepted byte == checksum -> DONE, with done=1 and cpu_hold=0 in the same cycle the state becomes DONE.
  - Accepted byte != checksum -> ERROR.
- ERROR: error=1, cpu_hold stays 1. Words already written are not rolled back.
- Timeout:
  - In LEN, DATA and CHECK, the counter increments every cycle without an accepted byte and clears on each accepted byte.
  - Reaching TIMEOUT -> ERROR.
  - A partially assembled word is discarded (no WE).
- WA/WD hold their last values when WE=0. WE is never asserted outside the cycle after a word completes.
- Reset mid-load: immediate return to the reset values; the memory retains partial contents; a new start is required.

Decomposition:
- Shared package imem_loader_pkg: state enum (IDLE, LEN, DATA, CHECK, DONE, ERROR) and width constant for words_loaded (clog2(DEPTH+1)).
- One sub-module, word_assembler: byte-position counter plus 32-bit little-endian shift register, with a word_valid pulse output and a clear input.

Test Plan:
- Nominal load:
  - Stimulus: start; bytes 02, 04,00,A0,E3, 00,10,81,E0, 36.
  - Response: WE pulses with WA=0x0/WD=0xE3A00004 and WA=0x4/WD=0xE0811000; then done=1, cpu_hold=0, words_loaded=2.
- Bad checksum:
  - Stimulus: same frame with CHK=37.
  - Response: both words written; error=1, done=0, cpu_hold=1.
- Illegal length:
  - Stimulus: LEN=00, then separately LEN=33 (0x21).
  - Response: error=1 on the cycle after acceptance; no WE.
- Timeout:
  - Stimulus: LEN=01, three data bytes, then idle TIMEOUT cycles.
  - Response: error=1, WE never asserted, words_loaded=0.
- Full image:
  - Stimulus: LEN=32 with rx_valid held high every cycle.
  - Response: 32 WE pulses; the last has WA=0x7C; rx_ready stays high through every data byte; done=1 after a correct CHK.
- Reset mid-DATA:
  - Stimulus: drop reset low after 5 data bytes.
  - Response: WE=0, cpu_hold=1, state=IDLE immediately; a subsequent start and the nominal frame load correctly.
